// File: rtl/op_sram_arbiter_pkg.sv
// Shared constants for the OP SRAM arbiter slice: geometry and requester indices.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: OP_AW/OP_DW (16x128 macro), NREQ, REQ_PSUM/REQ_SFU requester ids.
package op_sram_pkg;

  localparam int OP_AW = 4;
  localparam int OP_DW = 128;
  localparam int NREQ  = 2;

  localparam logic REQ_PSUM = 1'b0;  // corelet/OFIFO psum writeback
  localparam logic REQ_SFU  = 1'b1;  // SFU accumulate/readout

endpackage

// File: rtl/op_sram_arbiter_if.sv
// Requester-side bundle of the OP SRAM arbiter (both requesters packed together).
// Latency: reads return on rd_valid one cycle after the granted beat.
// Backpressure: a beat moves only when req_valid[i] & req_ready[i].
// Modports: master = requesters (psum, SFU), slave = arbiter.
interface op_sram_arbiter_if
  import op_sram_pkg::*;
#(
  parameter int AW = OP_AW,
  parameter int DW = OP_DW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;   // requester i at [i*AW +: AW]
  logic [NREQ*DW-1:0] req_wdata;  // requester i at [i*DW +: DW]
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rd_valid;
  logic [DW-1:0]      rd_data;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata,
    output req_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/op_sram_arbiter_rr_arb2.sv
// Two-way round-robin grant with a lock override; grant is combinational from registered state.
// Latency: grant in the same cycle as valid; last_grant updates at the edge.
// Backpressure: loser (or non-owner while locked) sees no grant and must hold its request.
// Ports: clk, reset (sync, active-high), en (arbitration allowed), valid[1:0],
//        lock_vld/lock_idx (current lock owner), grant[1:0] one-hot or zero.
module rr_arb2
  import op_sram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  input  logic       lock_vld,
  input  logic       lock_idx,
  output logic [1:0] grant
);

  // Index of the requester granted most recently; resets to SFU so psum wins the first conflict.
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (lock_vld && valid[lock_idx]) begin
        grant[lock_idx] = 1'b1;
      end else if (valid == 2'b11) begin
        grant = (last_grant == REQ_SFU) ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_SFU;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/op_sram_arbiter.sv
// OP SRAM port arbiter: psum writeback vs SFU, with host override of the macro pins.
// Latency: grant and SRAM pins same cycle as valid; rd_valid/rd_data one cycle after a granted read.
// Backpressure: one-hot req_ready; stalled requester holds valid; host_sel drops all readies.
// Ports: clk, reset; host_* override (host_sel=1 owns the macro); arb = requester bundle;
//        sram_cen/wen/addr/d to the macro, sram_q from it. Optional OP_ARB_STATS_EN adds
//        stat_grant0/stat_grant1/stat_conflict saturating 16-bit counters.
module op_sram_arbiter
  import op_sram_pkg::*;
#(
  parameter int AW = OP_AW,
  parameter int DW = OP_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_sel,
  input  logic          host_cen,
  input  logic          host_wen,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_d,
  op_sram_arbiter_if.slave arb,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
`ifdef OP_ARB_STATS_EN
  ,
  output logic [15:0]   stat_grant0,
  output logic [15:0]   stat_grant1,
  output logic [15:0]   stat_conflict
`endif
);

  logic          en;
  logic [1:0]    grant;
  logic          xfer;
  logic          gidx;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_d;
  logic          lock_vld;
  logic          lock_idx;
  logic [AW-1:0] addr_q;   // last granted address/data, held on idle cycles
  logic [DW-1:0] d_q;
  logic [1:0]    rd_vld_q;

  // Reset gating keeps readies low while reset is asserted.
  assign en   = ~reset & ~host_sel;
  assign xfer = |grant;   // grant implies valid, so any grant bit is a transfer
  assign gidx = grant[1];

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .valid    (arb.req_valid),
    .lock_vld (lock_vld),
    .lock_idx (lock_idx),
    .grant    (grant)
  );

  assign g_we   = arb.req_we[gidx];
  assign g_addr = gidx ? arb.req_addr[2*AW-1:AW]  : arb.req_addr[AW-1:0];
  assign g_d    = gidx ? arb.req_wdata[2*DW-1:DW] : arb.req_wdata[DW-1:0];

  assign arb.req_ready = grant;
  assign arb.rd_valid  = rd_vld_q;
  assign arb.rd_data   = sram_q;

  always_comb begin
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_addr = addr_q;
    sram_d    = d_q;
    if (reset) begin
      sram_addr = '0;
      sram_d    = '0;
    end else if (host_sel) begin
      sram_cen  = host_cen;
      sram_wen  = host_wen;
      sram_addr = host_addr;
      sram_d    = host_d;
    end else if (xfer) begin
      sram_cen  = 1'b0;
      sram_wen  = ~g_we;
      sram_addr = g_addr;
      sram_d    = g_d;
    end
  end

  // Lock survives only while the owner keeps transferring with req_lock set; any
  // cycle without an owner transfer (owner idle, host_sel, reset) drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_vld <= 1'b0;
      lock_idx <= REQ_PSUM;
      addr_q   <= '0;
      d_q      <= '0;
      rd_vld_q <= 2'b00;
    end else begin
      rd_vld_q <= grant & ~arb.req_we;
      lock_vld <= xfer & arb.req_lock[gidx];
      if (xfer) begin
        lock_idx <= gidx;
        addr_q   <= g_addr;
        d_q      <= g_d;
      end
    end
  end

`ifdef OP_ARB_STATS_EN
  logic conflict;
  // Both valid while arbitrating means exactly one of them stalls this cycle.
  assign conflict = en & (&arb.req_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant[0] && stat_grant0 != 16'hFFFF) stat_grant0 <= stat_grant0 + 16'd1;
      if (grant[1] && stat_grant1 != 16'hFFFF) stat_grant1 <= stat_grant1 + 16'd1;
      if (conflict && stat_conflict != 16'hFFFF) stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif

endmodule

// File: doc/op_sram_arbiter.md
Name: op_sram_arbiter

Overview:
- Two-requester arbiter for the single-port 16x128 OP SRAM.
- Requester 0 is the psum writeback path (corelet/OFIFO drain). Requester 1 is the SFU accumulate/readout path.
- Also owns the host-override mux, so the host can take the SRAM port for load/dump.
- Sits between the corelet/SFU and the OP SRAM macro inside core. Drives the macro's CEN/WEN/A/D directly.

Parameters:
- AW, 4, OP SRAM address width (16 entries)
- DW, 128, OP SRAM data width (col x psum_bw = 8 x 16)
- NREQ, 2, number of requesters; fixed at 2, present for package consistency only

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- host_sel  in  1  1 = host owns the SRAM port; arbiter grants nothing
- host_cen  in  1  host chip enable, active low
- host_wen  in  1  host write enable, active low
- host_addr  in  AW  host address
- host_d  in  DW  host write data
- req_valid  in  2  per-requester request valid
- req_we  in  2  per-requester: 1 = write, 0 = read
- req_lock  in  2  per-requester: hold the grant for the next beat while valid stays high
- req_addr  in  2*AW  packed addresses; requester i at [i*AW +: AW]
- req_wdata  in  2*DW  packed write data
- req_ready  out  2  one-hot grant; a beat transfers when valid & ready
- rd_valid  out  2  read data valid for requester i, one cycle after a granted read
- rd_data  out  DW  SRAM Q passthrough, shared by both requesters
- sram_cen  out  1  to macro CEN, active low
- sram_wen  out  1  to macro WEN, active low
- sram_addr  out  AW  to macro A
- sram_d  out  DW  to macro D
- sram_q  in  DW  from macro Q

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - req_ready = 0, rd_valid = 0.
  - sram_cen = 1, sram_wen = 1, sram_addr = 0, sram_d = 0.
  - last_grant = 1, so requester 0 wins the first conflict.
  - lock_owner register cleared.
- Arbitration is combinational from registered state:
  - If lock_owner is set and that requester's req_valid is high, it is granted.
  - Otherwise, if one requester is valid, it is granted.
  - If both are valid, the requester other than last_grant wins (round-robin).
- At most one req_ready bit is high per cycle. req_ready is never high for a requester whose valid is low.
- On a transfer (grant & valid):
  - sram_cen = 0 and sram_wen = ~req_we.
  - sram_addr and sram_d come from the granted requester.
  - last_grant is updated at the clock edge.
- Lock:
  - lock_owner is set at the edge after a transfer with req_lock = 1.
  - It is cleared at any edge where the owner's valid is low or the owner transfers with req_lock = 0.
  - While locked, the other requester waits. Worst-case wait equals the lock burst length.
- Read latency is 1 cycle. A granted read at cycle t gives rd_valid[i] = 1 at t+1, with rd_data = sram_q.
- Back-to-back reads from alternating requesters produce rd_valid on consecutive cycles with the correct index.
- With no transfer: sram_cen = 1, sram_wen = 1; sram_addr and sram_d hold their last values (registered mux select).
- host_sel = 1:
  - req_ready = 0.
  - SRAM pins are driven from the host_* ports combinationally.
  - lock_owner is cleared; last_grant is held.
  - A read granted in the cycle before host_sel rose still returns rd_valid on the next cycle.
- host_sel falling: arbitration resumes the same cycle.
- Reset mid-operation clears the pending rd_valid and lock. Nothing is reissued; requesters must re-present.
- Writes and reads to the same address in consecutive cycles are ordered by grant order. There is no forwarding; the SRAM provides read-after-write in order.

Optional Feature:
- Macro OP_ARB_STATS_EN.
- When defined, adds:
  - 16-bit saturating counters: stat_grant0, stat_grant1, stat_conflict (cycles with both valid and one stalled).
  - Outputs of the same names.
  - Counters clear on reset and saturate at 16'hFFFF.
- When undefined: no counters and no stat ports; all other behaviour is identical.

Decomposition:
- Package op_sram_pkg:
  - Constants OP_AW = 4, OP_DW = 128, NREQ = 2.
  - Requester index constants REQ_PSUM = 0, REQ_SFU = 1.
- Sub-module rr_arb2: 2-way round-robin grant with lock-override inputs, combinational grant plus last_grant register. The top level adds the SRAM mux, read-valid pipeline, host override and stats.

Test Plan:
- Single write: req0 valid, we = 1, addr = 3, data = 128'hA5 -> ready[0] = 1 the same cycle, sram_cen = 0, sram_wen = 0, sram_addr = 3. A later req1 read of addr 3 -> rd_valid[1] = 1 one cycle after grant, rd_data = 128'hA5.
- Both valid continuously, no lock, 6 cycles -> grants 0,1,0,1,0,1. stat_conflict = 6 when OP_ARB_STATS_EN is defined.
- req1 locked burst of 4 reads (addr 0..3) with req0 valid throughout -> ready[1] for 4 cycles, then req0 granted on cycle 5.
- host_sel raised the cycle after a req0 read grant -> rd_valid[0] = 1 next cycle, req_ready = 0 while host_sel = 1, host write to addr 15 appears on the SRAM pins.
- Reset asserted mid-lock with a read in flight -> next cycle rd_valid = 0, sram_cen = 1. After reset, req0 wins the first conflict.
